// File: rtl/wb_pkg.sv
// Shared sizes, payload type and index helpers for the writeback arbiter slice.
package wb_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned NUM_WP  = 2;
  localparam int unsigned PREG_W  = 7;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned GNT_W   = 2;

  typedef enum logic [IDX_W-1:0] {
    REQ_ALU = 2'd0,
    REQ_BR  = 2'd1,
    REQ_LSU = 2'd2
  } req_id_e;

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef logic [IDX_W-1:0] req_idx_t;

  // Requester index increment modulo NUM_REQ.
  function automatic req_idx_t next_idx(req_idx_t idx);
    return (idx == req_idx_t'(NUM_REQ - 1)) ? '0 : idx + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Requester offers and register-file write ports of the writeback arbiter.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic              alu_valid, br_valid, lsu_valid;
  logic              alu_ready, br_ready, lsu_ready;
  logic [PREG_W-1:0] alu_preg,  br_preg,  lsu_preg;
  logic [DATA_W-1:0] alu_data,  br_data,  lsu_data;

  logic              wp0_en,   wp1_en;
  logic [PREG_W-1:0] wp0_preg, wp1_preg;
  logic [DATA_W-1:0] wp0_data, wp1_data;

  modport master (
    output alu_valid, br_valid, lsu_valid,
    output alu_preg,  br_preg,  lsu_preg,
    output alu_data,  br_data,  lsu_data,
    input  alu_ready, br_ready, lsu_ready,
    input  wp0_en, wp1_en, wp0_preg, wp1_preg, wp0_data, wp1_data
  );

  modport slave (
    input  alu_valid, br_valid, lsu_valid,
    input  alu_preg,  br_preg,  lsu_preg,
    input  alu_data,  br_data,  lsu_data,
    output alu_ready, br_ready, lsu_ready,
    output wp0_en, wp1_en, wp0_preg, wp1_preg, wp0_data, wp1_data
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry result FIFO; slot 0 is always the head.
module wb_fifo2
  import wb_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      clear_i,
  input  logic      push_i,
  input  wb_entry_t push_entry_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  logic [1:0] cnt_q, cnt_d;
  wb_entry_t  slot_q [2];
  wb_entry_t  slot_d [2];
  logic       push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = slot_q[0];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pop shifts slot 1 forward; push lands in the first slot free after the pop.
  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (pop_ok) begin
      slot_d[0] = slot_q[1];
    end
    if (push_ok) begin
      if ((cnt_q - 2'(pop_ok)) == 2'd0) begin
        slot_d[0] = push_entry_i;
      end else begin
        slot_d[1] = push_entry_i;
      end
    end
    cnt_d = cnt_q + 2'(push_ok) - 2'(pop_ok);
    if (clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three FU result FIFOs drained round-robin onto two write ports.
// Optional flush port and logic are built when WB_FLUSH_EN is defined.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic clk,
  input  logic reset,
`ifdef WB_FLUSH_EN
  input  logic flush,
`endif
  wb_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] valid, ready, push, pop, full, empty;
  wb_entry_t          in_entry [NUM_REQ];
  wb_entry_t          head     [NUM_REQ];
  logic               flush_c;

  req_idx_t           rr_ptr_q, rr_ptr_d;
  logic [NUM_WP-1:0]  wp_en_q,  wp_en_d;
  wb_entry_t          wp_q     [NUM_WP];
  wb_entry_t          wp_d     [NUM_WP];

`ifdef WB_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign valid             = {bus.lsu_valid, bus.br_valid, bus.alu_valid};
  assign in_entry[REQ_ALU] = {bus.alu_preg, bus.alu_data};
  assign in_entry[REQ_BR]  = {bus.br_preg,  bus.br_data};
  assign in_entry[REQ_LSU] = {bus.lsu_preg, bus.lsu_data};

  // Ready reflects occupancy at the start of the cycle, so a same-cycle pop never raises it.
  assign ready         = {NUM_REQ{reset}} & ~full;
  assign bus.alu_ready = ready[REQ_ALU];
  assign bus.br_ready  = ready[REQ_BR];
  assign bus.lsu_ready = ready[REQ_LSU];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_fifo
    // preg 0 is handshaken but never stored.
    assign push[r] = valid[r] && ready[r] && (in_entry[r].preg != '0) && !flush_c;

    wb_fifo2 u_fifo (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (flush_c),
      .push_i       (push[r]),
      .push_entry_i (in_entry[r]),
      .pop_i        (pop[r]),
      .full_o       (full[r]),
      .empty_o      (empty[r]),
      .head_o       (head[r])
    );
  end

  // Round-robin scan from rr_ptr; first heads found fill write ports in order.
  always_comb begin
    logic [GNT_W-1:0] n_gnt;
    req_idx_t         idx;
    req_idx_t         last;
    pop      = '0;
    wp_en_d  = '0;
    wp_d     = wp_q;
    rr_ptr_d = rr_ptr_q;
    n_gnt    = '0;
    idx      = rr_ptr_q;
    last     = rr_ptr_q;
    if (!flush_c) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!empty[idx] && (n_gnt < GNT_W'(NUM_WP))) begin
          pop[idx]            = 1'b1;
          wp_en_d[1'(n_gnt)]  = 1'b1;
          wp_d[1'(n_gnt)]     = head[idx];
          last                = idx;
          n_gnt               = n_gnt + GNT_W'(1);
        end
        idx = next_idx(idx);
      end
      if (n_gnt != '0) begin
        rr_ptr_d = next_idx(last);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      wp_en_q  <= '0;
      for (int w = 0; w < int'(NUM_WP); w++) begin
        wp_q[w] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wp_en_q  <= wp_en_d;
      wp_q     <= wp_d;
    end
  end

  assign bus.wp0_en   = wp_en_q[0];
  assign bus.wp1_en   = wp_en_q[1];
  assign bus.wp0_preg = wp_q[0].preg;
  assign bus.wp1_preg = wp_q[1].preg;
  assign bus.wp0_data = wp_q[0].data;
  assign bus.wp1_data = wp_q[1].data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
`ifdef WB_FLUSH_EN
  logic flush = 1'b0;
`endif

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
`ifdef WB_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        d_valid [3];
  wb_entry_t   d_ent   [3];
  wb_entry_t   mq      [3][$];
  int          m_rr;
  logic        m_en    [2];
  wb_entry_t   m_wp    [2];
  logic        m_acc   [3];
  int unsigned preg_ctr = 1;

  function automatic logic m_ready(int r);
    return (reset === 1'b1) && (mq[r].size() < 2);
  endfunction

  function automatic logic [2:0] exp_rdy();
    return {m_ready(2), m_ready(1), m_ready(0)};
  endfunction

  function automatic logic [2:0] dut_rdy();
    return {bus.lsu_ready, bus.br_ready, bus.alu_ready};
  endfunction

  task automatic drive();
    bus.alu_valid = d_valid[0]; bus.alu_preg = d_ent[0].preg; bus.alu_data = d_ent[0].data;
    bus.br_valid  = d_valid[1]; bus.br_preg  = d_ent[1].preg; bus.br_data  = d_ent[1].data;
    bus.lsu_valid = d_valid[2]; bus.lsu_preg = d_ent[2].preg; bus.lsu_data = d_ent[2].data;
    #1;
  endtask

  // One clock edge; the model applies the arbitration rules to its queues.
  task automatic tick();
    logic rdy [3];
    logic fl;
    for (int r = 0; r < 3; r++) rdy[r] = m_ready(r);
    fl = 1'b0;
`ifdef WB_FLUSH_EN
    fl = (flush === 1'b1);
`endif
    @(posedge clk);
    for (int r = 0; r < 3; r++) m_acc[r] = d_valid[r] && rdy[r];
    if (reset !== 1'b1) begin
      for (int r = 0; r < 3; r++) mq[r].delete();
      m_rr = 0;
      for (int w = 0; w < 2; w++) begin m_en[w] = 1'b0; m_wp[w] = '0; end
    end else if (fl) begin
      for (int r = 0; r < 3; r++) mq[r].delete();
      m_en[0] = 1'b0; m_en[1] = 1'b0;
    end else begin
      int n;
      int idx;
      int last;
      n = 0; idx = m_rr; last = 0;
      m_en[0] = 1'b0; m_en[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (mq[idx].size() > 0 && n < 2) begin
          m_wp[n] = mq[idx].pop_front();
          m_en[n] = 1'b1;
          last = idx;
          n++;
        end
        idx = (idx + 1) % 3;
      end
      if (n > 0) m_rr = (last + 1) % 3;
      for (int r = 0; r < 3; r++)
        if (m_acc[r] && d_ent[r].preg != '0) mq[r].push_back(d_ent[r]);
    end
    #1;
  endtask

  task automatic clear_offers();
    for (int r = 0; r < 3; r++) d_valid[r] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_offers();
    drive();
    tick();
    reset = 1'b1;
    drive();
  endtask

  task automatic new_offer(int r);
    d_valid[r] = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 15) == 0) begin
      d_ent[r].preg = '0;
    end else begin
      d_ent[r].preg = PREG_W'(preg_ctr);
      preg_ctr = (preg_ctr == 127) ? 1 : preg_ctr + 1;
    end
    d_ent[r].data = $urandom();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int r = 0; r < 3; r++) begin
      d_valid[r] = 1'b1; d_ent[r].preg = PREG_W'(r + 1); d_ent[r].data = 32'h1111_0000 + r;
    end
    drive();
    checks++;
    if (dut_rdy() !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", dut_rdy()); end
    tick(); tick();
    checks++;
    if ({bus.wp0_en, bus.wp1_en} !== 2'b00) begin
      errors++; $display("FAIL reset_en got=%b%b exp=00", bus.wp0_en, bus.wp1_en);
    end
    checks++;
    if (bus.wp0_preg !== 7'd0 || bus.wp1_preg !== 7'd0 || bus.wp0_data !== 32'd0 || bus.wp1_data !== 32'd0) begin
      errors++; $display("FAIL reset_vals got=%0d/%h %0d/%h exp=0", bus.wp0_preg, bus.wp0_data, bus.wp1_preg, bus.wp1_data);
    end
    reset = 1'b1;
    clear_offers();
    drive();
    checks++;
    if (dut_rdy() !== 3'b111) begin errors++; $display("FAIL release_ready got=%b exp=111", dut_rdy()); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({bus.wp0_en, bus.wp1_en} !== 2'b00) begin
        errors++; $display("FAIL reset_push_dropped c=%0d got=%b%b exp=00", c, bus.wp0_en, bus.wp1_en);
      end
    end
  endtask

  task automatic test_single_latency();
    d_valid[0] = 1'b1; d_ent[0].preg = 7'd5; d_ent[0].data = 32'hDEAD_BEEF;
    drive();
    checks++;
    if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", bus.alu_ready); end
    tick();
    clear_offers();
    drive();
    checks++;
    if ({bus.wp0_en, bus.wp1_en} !== 2'b00) begin
      errors++; $display("FAIL single_early got=%b%b exp=00", bus.wp0_en, bus.wp1_en);
    end
    tick();
    checks++;
    if (bus.wp0_en !== 1'b1 || bus.wp0_preg !== 7'd5 || bus.wp0_data !== 32'hDEAD_BEEF || bus.wp1_en !== 1'b0) begin
      errors++; $display("FAIL single_write got en=%b%b p=%0d d=%h exp en=10 p=5 d=deadbeef",
                         bus.wp0_en, bus.wp1_en, bus.wp0_preg, bus.wp0_data);
    end
    tick();
    checks++;
    if (bus.wp0_en !== 1'b0 || bus.wp0_preg !== 7'd5 || bus.wp0_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_hold got en=%b p=%0d d=%h exp en=0 p=5 d=deadbeef",
                         bus.wp0_en, bus.wp0_preg, bus.wp0_data);
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int round = 0; round < 2; round++) begin
      for (int r = 0; r < 3; r++) begin
        d_valid[r] = 1'b1;
        d_ent[r].preg = PREG_W'(10 * (r + 1) + round);
        d_ent[r].data = 32'hA000_0000 + 32'(16 * round + r);
      end
      drive();
      tick();
      clear_offers();
      drive();
      tick();
      checks++;
      if (bus.wp0_en !== 1'b1 || bus.wp1_en !== 1'b1 || bus.wp0_preg !== PREG_W'(10 + round) ||
          bus.wp1_preg !== PREG_W'(20 + round)) begin
        errors++; $display("FAIL contend_first r=%0d got en=%b%b p=%0d,%0d exp en=11 p=%0d,%0d", round,
                           bus.wp0_en, bus.wp1_en, bus.wp0_preg, bus.wp1_preg, 10 + round, 20 + round);
      end
      tick();
      checks++;
      if (bus.wp0_en !== 1'b1 || bus.wp1_en !== 1'b0 || bus.wp0_preg !== PREG_W'(30 + round) ||
          bus.wp0_data !== 32'hA000_0000 + 32'(16 * round + 2)) begin
        errors++; $display("FAIL contend_second r=%0d got en=%b%b p=%0d d=%h exp en=10 p=%0d", round,
                           bus.wp0_en, bus.wp1_en, bus.wp0_preg, bus.wp0_data, 30 + round);
      end
    end
  endtask

  task automatic test_backpressure();
    wb_entry_t src [3][$];
    int        got [$];
    logic      saw_stall;
    wb_entry_t e;
    do_reset();
    saw_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e.preg = PREG_W'(50 + i); e.data = 32'h5000_0000 + 32'(i); src[0].push_back(e);
      e.preg = PREG_W'(60 + i); e.data = 32'h6000_0000 + 32'(i); src[1].push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      e.preg = PREG_W'(41 + i); e.data = 32'h4100_0000 + 32'(i); src[2].push_back(e);
    end
    for (int c = 0; c < 24; c++) begin
      for (int r = 0; r < 3; r++) begin
        d_valid[r] = (src[r].size() > 0);
        d_ent[r]   = (src[r].size() > 0) ? src[r][0] : '0;
      end
      drive();
      checks++;
      if (dut_rdy() !== exp_rdy()) begin
        errors++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, dut_rdy(), exp_rdy());
      end
      if (d_valid[2] && bus.lsu_ready === 1'b0) saw_stall = 1'b1;
      tick();
      for (int r = 0; r < 3; r++) if (m_acc[r]) void'(src[r].pop_front());
      checks++;
      if (bus.wp0_en !== m_en[0] || bus.wp1_en !== m_en[1] || bus.wp0_preg !== m_wp[0].preg ||
          bus.wp1_preg !== m_wp[1].preg || bus.wp0_data !== m_wp[0].data || bus.wp1_data !== m_wp[1].data) begin
        errors++; $display("FAIL bp_out c=%0d got en=%b%b p=%0d,%0d exp en=%b%b p=%0d,%0d", c,
                           bus.wp0_en, bus.wp1_en, bus.wp0_preg, bus.wp1_preg,
                           m_en[0], m_en[1], m_wp[0].preg, m_wp[1].preg);
      end
      if (bus.wp0_en === 1'b1 && bus.wp0_preg >= 7'd41 && bus.wp0_preg <= 7'd43) got.push_back(int'(bus.wp0_preg));
      if (bus.wp1_en === 1'b1 && bus.wp1_preg >= 7'd41 && bus.wp1_preg <= 7'd43) got.push_back(int'(bus.wp1_preg));
    end
    clear_offers();
    drive();
    checks++;
    if (saw_stall !== 1'b1) begin errors++; $display("FAIL bp_stall got=%b exp=1", saw_stall); end
    checks++;
    if (got.size() != 3 || got[0] != 41 || got[1] != 42 || got[2] != 43) begin
      errors++; $display("FAIL bp_order got n=%0d first=%0d exp 41,42,43", got.size(), (got.size() > 0) ? got[0] : -1);
    end
  endtask

  task automatic test_preg0();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      d_valid[1] = 1'b1; d_ent[1].preg = '0; d_ent[1].data = $urandom();
      drive();
      checks++;
      if (bus.br_ready !== 1'b1) begin errors++; $display("FAIL preg0_ready c=%0d got=%b exp=1", c, bus.br_ready); end
      tick();
    end
    clear_offers();
    for (int c = 0; c < 2; c++) begin
      drive();
      checks++;
      if ({bus.wp0_en, bus.wp1_en} !== 2'b00 || bus.br_ready !== 1'b1) begin
        errors++; $display("FAIL preg0_nowrite c=%0d got en=%b%b rdy=%b exp en=00 rdy=1",
                           c, bus.wp0_en, bus.wp1_en, bus.br_ready);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      d_valid[r] = 1'b1; d_ent[r].preg = PREG_W'(70 + r); d_ent[r].data = 32'h7000_0000 + 32'(r);
    end
    for (int c = 0; c < 3; c++) begin
      drive();
      tick();
      for (int r = 0; r < 3; r++)
        if (m_acc[r]) begin d_ent[r].preg = d_ent[r].preg + 7'd3; d_ent[r].data = d_ent[r].data + 32'd1; end
    end
    reset = 1'b0;
    drive();
    checks++;
    if (dut_rdy() !== 3'b000) begin errors++; $display("FAIL midrst_ready got=%b exp=000", dut_rdy()); end
    tick();
    checks++;
    if ({bus.wp0_en, bus.wp1_en} !== 2'b00 || bus.wp0_preg !== 7'd0 || bus.wp1_data !== 32'd0) begin
      errors++; $display("FAIL midrst_out got en=%b%b p0=%0d d1=%h exp 00/0/0", bus.wp0_en, bus.wp1_en,
                         bus.wp0_preg, bus.wp1_data);
    end
    reset = 1'b1;
    clear_offers();
    drive();
    checks++;
    if (dut_rdy() !== 3'b111) begin errors++; $display("FAIL midrst_release got=%b exp=111", dut_rdy()); end
    tick(); tick();
    checks++;
    if ({bus.wp0_en, bus.wp1_en} !== 2'b00) begin
      errors++; $display("FAIL midrst_stale got=%b%b exp=00", bus.wp0_en, bus.wp1_en);
    end
    d_valid[0] = 1'b1; d_ent[0].preg = 7'd9; d_ent[0].data = 32'h0000_0999;
    drive();
    tick();
    clear_offers();
    drive();
    tick();
    checks++;
    if (bus.wp0_en !== 1'b1 || bus.wp0_preg !== 7'd9 || bus.wp0_data !== 32'h0000_0999 || bus.wp1_en !== 1'b0) begin
      errors++; $display("FAIL midrst_fresh got en=%b%b p=%0d exp en=10 p=9", bus.wp0_en, bus.wp1_en, bus.wp0_preg);
    end
  endtask

`ifdef WB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 3; r++) begin
        d_valid[r] = 1'b1; d_ent[r].preg = PREG_W'(80 + 3 * c + r); d_ent[r].data = 32'h8000_0000 + 32'(3 * c + r);
      end
      drive();
      tick();
    end
    clear_offers();
    d_valid[0] = 1'b1; d_ent[0].preg = 7'd88; d_ent[0].data = 32'h8888_8888;
    flush = 1'b1;
    drive();
    tick();
    flush = 1'b0;
    clear_offers();
    drive();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({bus.wp0_en, bus.wp1_en} !== 2'b00) begin
        errors++; $display("FAIL flush_nowrite c=%0d got=%b%b exp=00", c, bus.wp0_en, bus.wp1_en);
      end
      tick();
    end
    checks++;
    if (dut_rdy() !== 3'b111) begin errors++; $display("FAIL flush_ready got=%b exp=111", dut_rdy()); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 3; r++) new_offer(r);
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
`ifdef WB_FLUSH_EN
      flush = ($urandom_range(0, 59) == 0);
`endif
      drive();
      checks++;
      if (dut_rdy() !== exp_rdy()) begin
        errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, dut_rdy(), exp_rdy());
      end
      tick();
      checks++;
      if (bus.wp0_en !== m_en[0] || bus.wp1_en !== m_en[1] || bus.wp0_preg !== m_wp[0].preg ||
          bus.wp1_preg !== m_wp[1].preg || bus.wp0_data !== m_wp[0].data || bus.wp1_data !== m_wp[1].data) begin
        errors++; $display("FAIL rand_out c=%0d got en=%b%b p=%0d/%h,%0d/%h exp en=%b%b p=%0d/%h,%0d/%h", c,
                           bus.wp0_en, bus.wp1_en, bus.wp0_preg, bus.wp0_data, bus.wp1_preg, bus.wp1_data,
                           m_en[0], m_en[1], m_wp[0].preg, m_wp[0].data, m_wp[1].preg, m_wp[1].data);
      end
      if (bus.wp0_en === 1'b1 && bus.wp1_en === 1'b1) begin
        checks++;
        if (bus.wp0_preg === bus.wp1_preg) begin
          errors++; $display("FAIL rand_unique c=%0d got p0=%0d p1=%0d exp distinct", c, bus.wp0_preg, bus.wp1_preg);
        end
      end
      for (int r = 0; r < 3; r++) if (m_acc[r] || !d_valid[r]) new_offer(r);
    end
    reset = 1'b1;
`ifdef WB_FLUSH_EN
    flush = 1'b0;
`endif
    clear_offers();
    drive();
  endtask

  initial begin
    for (int r = 0; r < 3; r++) begin d_valid[r] = 1'b0; d_ent[r] = '0; m_acc[r] = 1'b0; end
    for (int w = 0; w < 2; w++) begin m_en[w] = 1'b0; m_wp[w] = '0; end
    m_rr = 0;
    test_reset();
    test_single_latency();
    test_contention();
    test_backpressure();
    test_preg0();
    test_reset_mid();
`ifdef WB_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: reset, synchronous, active-low; clock clk.
REQ-003 SHALL have ports alu_valid/br_valid/lsu_valid, input, 1 each: requester 0/1/2 offers a result.
REQ-004 SHALL have ports alu_ready/br_ready/lsu_ready, output, 1 each: requester FIFO can accept this cycle.
REQ-005 SHALL have ports alu_preg/br_preg/lsu_preg, input, 7 each: destination physical register.
REQ-006 SHALL have ports alu_data/br_data/lsu_data, input, 32 each: result value.
REQ-007 SHALL have ports wp0_en/wp1_en, output, 1 each: register-file write port 0/1 enable, also the ready broadcast to the reservation stations.
REQ-008 SHALL have ports wp0_preg/wp1_preg, output, 7 each, and wp0_data/wp1_data, output, 32 each: write-port target and value.
REQ-009 SHALL have port flush, input, 1, only when WB_FLUSH_EN is defined: discard all pending results.

Function
REQ-010 SHALL hold one 2-entry FIFO per requester (0=ALU, 1=BR, 2=LSU), each entry {preg, data}.
REQ-011 SHALL drive x_ready = 1 iff that FIFO holds fewer than 2 entries; a pop in the same cycle does not raise ready.
REQ-012 SHALL push on x_valid && x_ready; valid while not ready is ignored, and the requester holds its offer.
REQ-013 SHALL accept but not enqueue a push with preg == 0, since physical register 0 is never written.
REQ-014 SHALL arbitrate each cycle among non-empty FIFO heads, scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
REQ-015 SHALL give the first head found to port 0 and the second to port 1, popping both in that cycle.
REQ-016 SHALL leave a third non-empty head waiting for a later cycle.
REQ-017 SHALL set rr_ptr to (last granted index + 1) mod 3 after any grant, and leave it unchanged when nothing is granted.
REQ-018 SHALL register the outputs: a grant in cycle N drives wpK_en=1 with that preg and data in cycle N+1.
REQ-019 SHALL give 1 cycle minimum latency from push edge to write-port assertion.
REQ-020 SHALL drive wpK_en=0 for any port that had no grant the previous cycle.
REQ-021 SHALL hold wpK_preg and wpK_data at their last values while wpK_en=0.
REQ-022 SHALL never drive wp0_preg == wp1_preg with both enables high; pregs are unique per rename.
REQ-023 SHALL preserve FIFO order within a requester; results are never reordered within one FU.

Reset
REQ-024 SHALL, while reset==0 at a clk edge, empty all FIFOs and set rr_ptr=0.
REQ-025 SHALL, under the same condition, set wp0_en, wp1_en, wp0_preg, wp1_preg, wp0_data and wp1_data to 0.
REQ-026 SHALL force all x_ready=0 while reset==0 and drop any push in that cycle.
REQ-027 SHALL, on reset asserted mid-operation, lose all pending results; the first push after release is treated as fresh.

Configuration
REQ-028 SHALL add the flush port when WB_FLUSH_EN is defined.
REQ-029 SHALL, on flush=1 at an edge, empty all FIFOs, drop same-cycle pushes and force wp0_en=wp1_en=0 next cycle.
REQ-030 SHALL leave rr_ptr unchanged on flush.
REQ-031 SHALL omit the flush port and logic when WB_FLUSH_EN is undefined, with all other behaviour identical.

Structure
REQ-032 SHALL take NUM_REQ=3, NUM_WP=2, PREG_W=7, DATA_W=32 and typedef wb_entry_t {preg, data} from shared package wb_pkg.
REQ-033 SHALL instantiate sub-module wb_fifo2 (2-entry FIFO with push, pop, full, empty, head) three times.

Verification
REQ-034 SHALL cover single-result latency: ALU pushes preg=5, data=0xDEADBEEF in cycle 0 -> cycle 1 has wp0_en=1, wp0_preg=5, wp0_data=0xDEADBEEF, and wp1_en=0.
REQ-035 SHALL cover three-way contention: all three push in cycle 0 (pregs 10, 20, 30) with rr_ptr=0 -> cycle 1 writes ports 10 and 20, cycle 2 writes port0=30, rr_ptr ends at 0.
REQ-036 SHALL cover backpressure: LSU pushes 3 times back-to-back while ports are saturated by ALU/BR -> lsu_ready=0 after 2 entries, the third is held, and none is lost or reordered.
REQ-037 SHALL cover preg 0: BR pushes preg=0 -> br_ready stays 1, no write-port assertion, and the FIFO stays empty.
REQ-038 SHALL cover reset: reset=0 with 2 entries pending in each FIFO -> next cycle all wp*_en=0 and x_ready=0; after release, x_ready=1.
REQ-039 SHALL cover flush under WB_FLUSH_EN: flush=1 with 4 entries pending plus a same-cycle ALU push -> no writes on the following 3 cycles.
